vector_load_unit: RTL and testbench

- Gather stage between the shared single-port data memory and the multi-core register file.
- Takes one request (base word address, lane count) and issues consecutive synchronous reads base, base+1, …, base+count-1.
- Packs the results into one lane vector (lane k = mem[base+k]) and hands it downstream with a valid/ready handshake.
- Lets the cores load e.g. registers 9/10/11 in one logical step.

---
 rtl/vlu_pkg.sv | 26 ++
 rtl/vlu_lane_pack.sv | 35 +++
 rtl/vector_load_unit.sv | 199 +++++++++++++++++++
 tb/tb_vector_load_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vlu_pkg.sv
// Shared definitions for the vector load unit: FSM states, lane-index sizing
// and the helper that locates a lane inside the packed response vector.
package vlu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } vlu_state_e;

  localparam int VLU_DEF_CORES = 4;

  // Bits needed to name one lane; a single-lane build still gets one bit.
  function automatic int lane_idx_w(input int cores);
    return (cores > 1) ? $clog2(cores) : 1;
  endfunction

  localparam int VLU_LANE_IDX_W = lane_idx_w(VLU_DEF_CORES);

  // Lowest bit of lane 'lane' in a vector of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/vlu_lane_pack.sv
// Capture register for the gathered vector: one word slot and one valid bit
// per lane, written one lane at a time and wiped when a new request starts.
module vlu_lane_pack
  import vlu_pkg::*;
#(
  parameter int CORES = VLU_DEF_CORES,
  parameter int WIDTH = 32,
  parameter int IDX_W = lane_idx_w(CORES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [WIDTH-1:0]       wdata,
  output logic [CORES*WIDTH-1:0] data,
  output logic [CORES-1:0]       mask
);

  // Store the returned word into the addressed lane and flag that lane as loaded.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      data <= '0;
      mask <= '0;
    end else if (we) begin
      for (int k = 0; k < CORES; k++) begin
        if (idx == IDX_W'(k)) begin
          data[lane_lsb(k, WIDTH) +: WIDTH] <= wdata;
          mask[k]                           <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vector_load_unit.sv
// Gathers up to CORES consecutive words from the single-port data memory,
// one read per cycle, and hands them downstream as one lane vector.
// Optional build macro VLU_BOUNDS_CHECK_EN: lanes beyond MEM_DEPTH are
// skipped instead of wrapping, and an rsp_err output reports them.
module vector_load_unit
  import vlu_pkg::*;
#(
  parameter int CORES     = VLU_DEF_CORES,
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_base,
  input  logic [$clog2(CORES+1)-1:0] req_count,
  output logic                       mem_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [WIDTH-1:0]           mem_rdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [CORES*WIDTH-1:0]     rsp_data,
  output logic [CORES-1:0]           rsp_mask
`ifdef VLU_BOUNDS_CHECK_EN
  ,
  output logic                       rsp_err
`endif
);

  localparam int CNT_W = $clog2(CORES + 1);
  localparam int IDX_W = lane_idx_w(CORES);

  vlu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  issue_q;
  logic [CNT_W-1:0]  count_clamped;
  logic              accept;
  logic              issue_more;

  // A "slot" is one lane's turn on the memory port; it is spent even when the
  // lane is skipped, so the response timing never depends on the address.
  logic              slot_go;
  logic              slot_inb;
  logic [ADDR_W-1:0] slot_base;
  logic [CNT_W-1:0]  slot_k;
  logic [ADDR_W-1:0] slot_addr;
  logic              slot_q;
  logic              cap_live_q;
  logic              cap_rd_q;
  logic [IDX_W-1:0]  cap_idx_q;

  // Requests asking for more lanes than exist are trimmed to the full vector.
  always_comb begin
    count_clamped = req_count;
    if (req_count > CNT_W'(CORES)) begin
      count_clamped = CNT_W'(CORES);
    end
  end

  // Next-state logic plus the accept and issue strobes that steer the datapath.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    issue_more = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (count_clamped == '0) ? RESP : FETCH;
        end
      end
      FETCH: begin
        if (issue_q < count_q) begin
          issue_more = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pick which lane is presented to memory this cycle; the first one comes
  // straight from the request since base/count are not latched yet.
  always_comb begin
    slot_go   = 1'b0;
    slot_base = base_q;
    slot_k    = issue_q;
    if (accept && (count_clamped != '0)) begin
      slot_go   = 1'b1;
      slot_base = req_base;
      slot_k    = '0;
    end else if (issue_more) begin
      slot_go = 1'b1;
    end
    slot_addr = slot_base + ADDR_W'(slot_k);
  end

`ifdef VLU_BOUNDS_CHECK_EN
  logic [31:0] slot_unwrapped;
  logic        err_q;

  assign slot_unwrapped = 32'(slot_base) + 32'(slot_k);
  assign slot_inb       = (slot_unwrapped < 32'(MEM_DEPTH));
  assign rsp_err        = err_q;

  // Remember any skipped lane until the consumer takes the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept || (state_q == RESP && rsp_ready)) begin
      err_q <= 1'b0;
    end else if (slot_go && !slot_inb) begin
      err_q <= 1'b1;
    end
  end
`else
  assign slot_inb = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, read issue and the two-stage tracking of when read data
  // lands: memory samples the address one edge after issue and the word is
  // captured on the edge after that.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q     <= '0;
      count_q    <= '0;
      issue_q    <= '0;
      slot_q     <= 1'b0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      cap_live_q <= 1'b0;
      cap_rd_q   <= 1'b0;
      cap_idx_q  <= '0;
    end else begin
      slot_q     <= slot_go;
      mem_en     <= slot_go && slot_inb;
      cap_live_q <= slot_q;
      cap_rd_q   <= mem_en;
      if (slot_go) begin
        mem_addr <= slot_addr;
      end
      if (accept) begin
        base_q    <= req_base;
        count_q   <= count_clamped;
        issue_q   <= CNT_W'(1);
        cap_idx_q <= '0;
      end else begin
        if (issue_more) begin
          issue_q <= issue_q + CNT_W'(1);
        end
        if (cap_live_q) begin
          cap_idx_q <= cap_idx_q + IDX_W'(1);
        end
      end
    end
  end

  vlu_lane_pack #(
    .CORES (CORES),
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_pack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .we    (cap_live_q && cap_rd_q),
    .idx   (cap_idx_q),
    .wdata (mem_rdata),
    .data  (rsp_data),
    .mask  (rsp_mask)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

endmodule

// File: tb/tb_vector_load_unit.sv
// Self-checking bench for vector_load_unit: a behavioural memory answers the
// reads, a scoreboard queue holds the expected vector of each request.
module tb_vector_load_unit;

  localparam int CORES     = 4;
  localparam int WIDTH     = 32;
  localparam int ADDR_W    = 10;
  localparam int MEM_DEPTH = 1024;
  localparam int CNT_W     = $clog2(CORES + 1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_W-1:0]      req_base;
  logic [CNT_W-1:0]       req_count;
  logic                   mem_en;
  logic [ADDR_W-1:0]      mem_addr;
  logic [WIDTH-1:0]       mem_rdata = '0;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [CORES*WIDTH-1:0] rsp_data;
  logic [CORES-1:0]       rsp_mask;
`ifdef VLU_BOUNDS_CHECK_EN
  logic                   rsp_err;
`endif

  typedef struct {
    logic [CORES*WIDTH-1:0] data;
    logic [CORES-1:0]       mask;
    logic                   err;
    int                     lat;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [ADDR_W-1:0] addr_log[$];
  logic [WIDTH-1:0]  mem[MEM_DEPTH];
  int                cyc = 0;
  int                tests_run = 0;
  int                tests_failed = 0;

  vector_load_unit #(
    .CORES     (CORES),
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_base  (req_base),
    .req_count (req_count),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_mask  (rsp_mask)
`ifdef VLU_BOUNDS_CHECK_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  always #5 clk = ~clk;

  // Edge counter used to measure request-to-response latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port memory: data appears one edge after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      addr_log.push_back(mem_addr);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] expected);
    tests_run++;
    if (got !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ready"}, 128'(req_ready), 128'(1));
    checkOutput({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    checkOutput({tag, "_mem_en"},    128'(mem_en),    128'(0));
    checkOutput({tag, "_mem_addr"},  128'(mem_addr),  128'(0));
    checkOutput({tag, "_rsp_data"},  128'(rsp_data),  128'(0));
    checkOutput({tag, "_rsp_mask"},  128'(rsp_mask),  128'(0));
`ifdef VLU_BOUNDS_CHECK_EN
    checkOutput({tag, "_rsp_err"},   128'(rsp_err),   128'(0));
`endif
  endtask

  // Drive one request, predict its vector, then wait for and check the response,
  // optionally stalling the consumer for 'hold' cycles first. Starts and ends on a negedge.
  task automatic applyStimulus(input int base, input int count, input int hold);
    exp_t e;
    int   n;
    int   acc;
    int   rise;
    bit   seen;
    n     = (count > CORES) ? CORES : count;
    e.data = '0;
    e.mask = '0;
    e.err  = 1'b0;
    // an empty request answers at the accept edge itself
    e.lat  = (n == 0) ? 0 : n + 1;
    exp_addr_q.delete();
    for (int k = 0; k < n; k++) begin
      int a;
      a = base + k;
`ifdef VLU_BOUNDS_CHECK_EN
      if (a >= MEM_DEPTH) begin
        e.err = 1'b1;
        continue;
      end
`endif
      a = a % (1 << ADDR_W);
      e.data[k*WIDTH +: WIDTH] = mem[a];
      e.mask[k] = 1'b1;
      exp_addr_q.push_back(ADDR_W'(a));
    end
    exp_q.push_back(e);

    addr_log.delete();
    req_valid = 1'b1;
    req_base  = ADDR_W'(base);
    req_count = CNT_W'(count);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      checkOutput("accept_timeout", 128'(req_ready), 128'(1));
      req_valid = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc       = cyc;
    req_valid = 1'b0;
    req_base  = '0;
    req_count = '0;

    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checkOutput("rsp_timeout", 128'(rsp_valid), 128'(1));
      exp_q.delete();
      return;
    end
    rise = cyc;
    e = exp_q.pop_front();
    checkOutput("latency", 128'(rise - acc), 128'(e.lat));

    for (int i = 0; i < hold; i++) begin
      checkOutput("held_data",      128'(rsp_data),  128'(e.data));
      checkOutput("held_valid",     128'(rsp_valid), 128'(1));
      checkOutput("req_ready_busy", 128'(req_ready), 128'(0));
      @(negedge clk);
    end

    checkOutput("rsp_data", 128'(rsp_data), 128'(e.data));
    checkOutput("rsp_mask", 128'(rsp_mask), 128'(e.mask));
`ifdef VLU_BOUNDS_CHECK_EN
    checkOutput("rsp_err",  128'(rsp_err),  128'(e.err));
`endif
    checkOutput("read_count", 128'(addr_log.size()), 128'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < addr_log.size(); i++) begin
      checkOutput("read_addr", 128'(addr_log[i]), 128'(exp_addr_q[i]));
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("idle_after_hs",  128'(req_ready), 128'(1));
    checkOutput("valid_after_hs", 128'(rsp_valid), 128'(0));
`ifdef VLU_BOUNDS_CHECK_EN
    checkOutput("err_after_hs",   128'(rsp_err),   128'(0));
`endif
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = WIDTH'(i + 1);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_base  = '0;
    req_count = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("por");
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 3, 0);
    applyStimulus(3, 3, 5);
    applyStimulus(6, 7, 0);
    applyStimulus(5, 0, 0);
    applyStimulus(1022, 4, 0);

    // Reset in the middle of a fetch; this request is abandoned, so nothing is queued for it.
    req_valid = 1'b1;
    req_base  = '0;
    req_count = CNT_W'(4);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_count = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetState("mid_fetch_rst");
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 2, 0);

    for (int r = 0; r < 4; r++) begin
      applyStimulus(int'($urandom_range(0, MEM_DEPTH - 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
